// File: rtl/scl_pkg.sv
`default_nettype none
// =====================================================================
// Package  : scl_pkg
// Brief    : Shared state encoding, config constants and keep rule
// Revision : 1.0
// =====================================================================
package scl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HBLANK = 2'd2,
        ST_DONE   = 2'd3
    } scl_state_e;

    localparam logic SCL_BYPASS  = 1'b0;
    localparam logic SCL_HALF    = 1'b0;
    localparam logic SCL_QUARTER = 1'b1;

    // Only the last pixel of each complete 2- or 4-pixel group is emitted,
    // so an incomplete trailing group is never kept.
    function automatic logic scl_keep(input logic mode, input logic rsz,
                                      input logic [1:0] x_lo);
        if (mode == SCL_BYPASS)
            return 1'b1;
        else if (rsz == SCL_HALF)
            return x_lo[0];
        else
            return &x_lo;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scl_line_cnt.sv
`default_nettype none
// =====================================================================
// Module   : scl_line_cnt
// Brief    : Pixel index counter with saturation and line length check
// Revision : 1.0
// =====================================================================
module scl_line_cnt #(
    parameter int X_W   = 12,
    parameter int MAX_W = 2048
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    input  logic           clr_i,
    input  logic           inc_i,
    input  logic           eol_i,
    input  logic           first_i,
    output logic [X_W-1:0] x_o,
    output logic           sat_o,
    output logic           mismatch_o
);

    localparam logic [X_W-1:0] X_MAX = X_W'(MAX_W - 1);

    logic [X_W-1:0] x_q, x_d;
    logic [X_W:0]   w0_q, w0_d;
    logic [X_W:0]   w_len;

    assign w_len      = {1'b0, x_q} + {{X_W{1'b0}}, 1'b1};
    assign sat_o      = inc_i && (x_q == X_MAX);
    assign mismatch_o = eol_i && !first_i && (w_len != w0_q);
    assign x_o        = x_q;

    always_comb begin
        x_d  = x_q;
        w0_d = w0_q;
        if (clr_i)
            x_d = '0;
        else if (inc_i && !sat_o)
            x_d = x_q + X_W'(1);
        // Line 0 of every frame sets the reference width for that frame
        if (eol_i && first_i)
            w0_d = w_len;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            x_q  <= '0;
            w0_q <= '0;
        end else begin
            x_q  <= x_d;
            w0_q <= w0_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/scl_seq_ctrl.sv
`default_nettype none
// =====================================================================
// Module   : scl_seq_ctrl
// Brief    : Frame/line sequencer and config shadow for the scaler path
// Revision : 1.0
// =====================================================================
module scl_seq_ctrl
    import scl_pkg::*;
#(
    parameter int X_W   = 12,
    parameter int IMG_H = 1024,
    parameter int MAX_W = 2048
) (
    input  logic           clk_scl,
    input  logic           rst_n_scl,
    input  logic           scl_i_vsync,
    input  logic           scl_i_hsync,
    input  logic           scl_i_data_en,
    input  logic           scl_cfg_mode,
    input  logic           scl_cfg_rsz,
    input  logic [1:0]     scl_cfg_flt,
    output logic           ctl_mode,
    output logic           ctl_rsz,
    output logic [1:0]     ctl_flt,
    output logic           ctl_sof,
    output logic           ctl_sol,
    output logic           ctl_eol,
    output logic           ctl_keep,
    output logic [X_W-1:0] ctl_px_x,
    output logic [X_W-1:0] ctl_ln_y,
    output logic           ctl_busy,
    output logic           ctl_err_len
);

    localparam logic [X_W-1:0] Y_LAST = X_W'(IMG_H - 1);

    scl_state_e     state_q;
    logic           den_q;
    logic           mode_q, rsz_q;
    logic [1:0]     flt_q;
    logic           sof_q, sol_q, eol_q, keep_q, busy_q, err_q;
    logic [X_W-1:0] y_q;

    logic           w_rise, w_start, w_adv, w_eol, w_clr;
    logic           w_sat, w_mismatch;
    logic [X_W-1:0] w_x;
    logic [1:0]     w_x_lo_nxt;
    logic           w_unused_hsync;

    assign w_unused_hsync = scl_i_hsync;

    assign w_rise     = scl_i_data_en && !den_q;
    assign w_start    = scl_i_vsync && (((state_q == ST_IDLE) && w_rise) ||
                                        ((state_q == ST_HBLANK) && scl_i_data_en));
    assign w_adv      = scl_i_vsync && (state_q == ST_ACTIVE) && scl_i_data_en;
    assign w_eol      = scl_i_vsync && (state_q == ST_ACTIVE) && !scl_i_data_en;
    assign w_clr      = !scl_i_vsync || w_start;
    assign w_x_lo_nxt = w_x[1:0] + 2'd1;

    scl_line_cnt #(
        .X_W   (X_W),
        .MAX_W (MAX_W)
    ) u_line_cnt (
        .clk_i      (clk_scl),
        .rst_n_i    (rst_n_scl),
        .clr_i      (w_clr),
        .inc_i      (w_adv),
        .eol_i      (w_eol),
        .first_i    (y_q == '0),
        .x_o        (w_x),
        .sat_o      (w_sat),
        .mismatch_o (w_mismatch)
    );

    always_ff @(posedge clk_scl or negedge rst_n_scl) begin
        if (!rst_n_scl) begin
            state_q <= ST_IDLE;
            den_q   <= 1'b0;
            mode_q  <= 1'b0;
            rsz_q   <= 1'b0;
            flt_q   <= 2'b00;
            sof_q   <= 1'b0;
            sol_q   <= 1'b0;
            eol_q   <= 1'b0;
            keep_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            y_q     <= '0;
        end else begin
            den_q  <= scl_i_data_en;
            sof_q  <= 1'b0;
            sol_q  <= 1'b0;
            eol_q  <= 1'b0;
            keep_q <= 1'b0;
            if (!scl_i_vsync) begin
                // Resync keeps the shadow config and the sticky error
                state_q <= ST_IDLE;
                y_q     <= '0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (w_rise) begin
                            state_q <= ST_ACTIVE;
                            mode_q  <= scl_cfg_mode;
                            rsz_q   <= scl_cfg_rsz;
                            flt_q   <= scl_cfg_flt;
                            sof_q   <= 1'b1;
                            sol_q   <= 1'b1;
                            keep_q  <= scl_keep(scl_cfg_mode, scl_cfg_rsz, 2'b00);
                            err_q   <= 1'b0;
                            busy_q  <= 1'b1;
                            y_q     <= '0;
                        end
                    end
                    ST_ACTIVE: begin
                        if (scl_i_data_en) begin
                            keep_q <= !w_sat && scl_keep(mode_q, rsz_q, w_x_lo_nxt);
                            if (w_sat)
                                err_q <= 1'b1;
                        end else begin
                            eol_q <= 1'b1;
                            if (w_mismatch)
                                err_q <= 1'b1;
                            if (y_q == Y_LAST) begin
                                state_q <= ST_DONE;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= ST_HBLANK;
                                y_q     <= y_q + X_W'(1);
                            end
                        end
                    end
                    ST_HBLANK: begin
                        if (scl_i_data_en) begin
                            state_q <= ST_ACTIVE;
                            sol_q   <= 1'b1;
                            keep_q  <= scl_keep(mode_q, rsz_q, 2'b00);
                        end
                    end
                    ST_DONE: state_q <= ST_IDLE;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign ctl_mode    = mode_q;
    assign ctl_rsz     = rsz_q;
    assign ctl_flt     = flt_q;
    assign ctl_sof     = sof_q;
    assign ctl_sol     = sol_q;
    assign ctl_eol     = eol_q;
    assign ctl_keep    = keep_q;
    assign ctl_px_x    = w_x;
    assign ctl_ln_y    = y_q;
    assign ctl_busy    = busy_q;
    assign ctl_err_len = err_q;

endmodule
`default_nettype wire

// File: tb/tb_scl_seq_ctrl.sv
`default_nettype none
// =====================================================================
// Module   : tb_scl_seq_ctrl
// Brief    : Self-checking bench for the scaler frame/line sequencer
// Revision : 1.0
// =====================================================================
module tb_scl_seq_ctrl;

    localparam int X_W   = 12;
    localparam int IMG_H = 2;
    localparam int MAX_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic vs = 1'b1, hs = 1'b1, den = 1'b0, mode = 1'b0, rsz = 1'b0;
    logic [1:0] flt = 2'b00;

    logic           ctl_mode, ctl_rsz, ctl_sof, ctl_sol, ctl_eol, ctl_keep;
    logic           ctl_busy, ctl_err_len;
    logic [1:0]     ctl_flt;
    logic [X_W-1:0] ctl_px_x, ctl_ln_y;

    scl_seq_ctrl #(.X_W(X_W), .IMG_H(IMG_H), .MAX_W(MAX_W)) dut (
        .clk_scl       (clk),
        .rst_n_scl     (rst_n),
        .scl_i_vsync   (vs),
        .scl_i_hsync   (hs),
        .scl_i_data_en (den),
        .scl_cfg_mode  (mode),
        .scl_cfg_rsz   (rsz),
        .scl_cfg_flt   (flt),
        .ctl_mode      (ctl_mode),
        .ctl_rsz       (ctl_rsz),
        .ctl_flt       (ctl_flt),
        .ctl_sof       (ctl_sof),
        .ctl_sol       (ctl_sol),
        .ctl_eol       (ctl_eol),
        .ctl_keep      (ctl_keep),
        .ctl_px_x      (ctl_px_x),
        .ctl_ln_y      (ctl_ln_y),
        .ctl_busy      (ctl_busy),
        .ctl_err_len   (ctl_err_len)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- behavioural model ----------------
    bit in_frame = 0, in_line = 0, hold = 0, prev = 0;
    int px = 0, ln = 0, w0 = 0;
    bit e_mode = 0, e_rsz = 0, e_sof = 0, e_sol = 0, e_eol = 0, e_keep = 0;
    bit e_busy = 0, e_err = 0;
    bit [1:0] e_flt = 0;

    function automatic bit keep_of(bit m, bit r, int p);
        int g;
        g = (m == 1'b0) ? 1 : (r ? 4 : 2);
        return ((p + 1) % g) == 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_frame = 0; in_line = 0; hold = 0; prev = 0;
            px = 0; ln = 0; w0 = 0;
            e_mode = 0; e_rsz = 0; e_flt = 0; e_sof = 0; e_sol = 0;
            e_eol = 0; e_keep = 0; e_busy = 0; e_err = 0;
        end else begin
            e_sof = 0; e_sol = 0; e_eol = 0; e_keep = 0;
            if (!vs) begin
                in_frame = 0; in_line = 0; hold = 0; px = 0; ln = 0; e_busy = 0;
            end else if (hold) begin
                hold = 0;
            end else if (!in_frame) begin
                if (den && !prev) begin
                    e_mode = mode; e_rsz = rsz; e_flt = flt;
                    e_err = 0; in_frame = 1; in_line = 1; px = 0; ln = 0;
                    e_sof = 1; e_sol = 1; e_busy = 1;
                    e_keep = keep_of(e_mode, e_rsz, 0);
                end
            end else if (in_line) begin
                if (den) begin
                    if (px == MAX_W - 1) e_err = 1;
                    else begin
                        px = px + 1;
                        e_keep = keep_of(e_mode, e_rsz, px);
                    end
                end else begin
                    e_eol = 1; in_line = 0;
                    if (ln == 0) w0 = px + 1;
                    else if (px + 1 != w0) e_err = 1;
                    if (ln == IMG_H - 1) begin
                        in_frame = 0; e_busy = 0; hold = 1;
                    end else ln = ln + 1;
                end
            end else if (den) begin
                in_line = 1; px = 0; e_sol = 1;
                e_keep = keep_of(e_mode, e_rsz, 0);
            end
            prev = den;
        end
    end

    // ---------------- compare + monitor ----------------
    wire [33:0] outs = {ctl_mode, ctl_rsz, ctl_flt, ctl_sof, ctl_sol, ctl_eol,
                        ctl_keep, ctl_busy, ctl_err_len, ctl_px_x, ctl_ln_y};
    int c_sof = 0, c_sol = 0, c_eol = 0, c_keep = 0;
    logic [31:0] mask = 0;

    always @(negedge clk) begin
        logic [33:0] exp_v;
        exp_v = {e_mode, e_rsz, e_flt, e_sof, e_sol, e_eol, e_keep, e_busy, e_err,
                 X_W'(px), X_W'(ln)};
        n_tests++;
        if (outs !== exp_v) begin
            n_fail++;
            $display("FAIL cycle_model t=%0t got=%h expected=%h (mode,rsz,flt,sof,sol,eol,keep,busy,err,x,y)",
                     $time, outs, exp_v);
        end
        if (ctl_sof)  c_sof++;
        if (ctl_sol)  c_sol++;
        if (ctl_eol)  c_eol++;
        if (ctl_keep) begin
            c_keep++;
            mask = mask | (32'd1 << ctl_px_x);
        end
    end

    // ---------------- stimulus ----------------
    task automatic chk(input string nm, input int got, input int expv);
        n_tests++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", nm, got, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic line(input int n, input int gap);
        den = 1'b1; hs = 1'b0;
        tick(n);
        den = 1'b0; hs = 1'b1;
        tick(gap);
    endtask

    task automatic clr_mon();
        c_sof = 0; c_sol = 0; c_eol = 0; c_keep = 0; mask = 0;
    endtask

    initial begin
        tick(3);
        chk("reset_outputs_zero", int'(|outs), 0);
        rst_n = 1'b1;
        tick(2);

        // Bypass, two 8-pixel lines
        mode = 0; rsz = 0; flt = 2'b01; clr_mon();
        line(8, 100);
        chk("bypass_busy_midframe", int'(ctl_busy), 1);
        line(8, 100);
        chk("bypass_keeps", c_keep, 16);
        chk("bypass_sol", c_sol, 2);
        chk("bypass_eol", c_eol, 2);
        chk("bypass_sof", c_sof, 1);
        chk("bypass_err", int'(ctl_err_len), 0);
        chk("bypass_busy_end", int'(ctl_busy), 0);
        chk("flt_shadow", int'(ctl_flt), 1);

        // Half width
        mode = 1; rsz = 0; flt = 2'b10; clr_mon();
        line(8, 20);
        chk("half8_mask", int'(mask), 32'hAA);
        clr_mon();
        line(7, 20);
        chk("half7_mask", int'(mask), 32'h2A);
        chk("half7_err", int'(ctl_err_len), 1);

        // Quarter width; mid-frame config change must not take effect
        mode = 1; rsz = 1; clr_mon();
        line(8, 20);
        chk("quarter_mask", int'(mask), 32'h88);
        mode = 0; clr_mon();
        line(8, 20);
        chk("quarter_cfg_held", int'(mask), 32'h88);
        chk("quarter_err", int'(ctl_err_len), 0);
        clr_mon();
        line(8, 20);
        chk("new_frame_bypass_mask", int'(mask), 32'hFF);
        chk("new_frame_mode", int'(ctl_mode), 0);
        line(8, 20);

        // Line length mismatch, cleared on next frame start
        line(8, 20);
        den = 1'b1; tick(6); den = 1'b0; tick(1);
        chk("mismatch_eol", int'(ctl_eol), 1);
        chk("mismatch_err", int'(ctl_err_len), 1);
        tick(20);
        den = 1'b1; tick(1);
        chk("err_clear_sof", int'(ctl_sof), 1);
        chk("err_clear_err", int'(ctl_err_len), 0);
        tick(7); den = 1'b0; tick(20);
        line(8, 20);

        // Vsync resync in the middle of line 1
        line(8, 20);
        den = 1'b1; tick(4);
        chk("vs_pre_x", int'(ctl_px_x), 3);
        chk("vs_pre_y", int'(ctl_ln_y), 1);
        vs = 1'b0; tick(1);
        chk("vs_x", int'(ctl_px_x), 0);
        chk("vs_y", int'(ctl_ln_y), 0);
        chk("vs_busy", int'(ctl_busy), 0);
        clr_mon();
        vs = 1'b1; tick(2); den = 1'b0; tick(10);
        chk("vs_no_eol", c_eol, 0);
        den = 1'b1; tick(1);
        chk("vs_next_sof", int'(ctl_sof), 1);
        chk("vs_next_y", int'(ctl_ln_y), 0);
        tick(7); den = 1'b0; tick(20);
        line(8, 20);

        // Asynchronous reset mid-line
        den = 1'b1; tick(6);
        chk("rst_pre_x", int'(ctl_px_x), 5);
        #2 rst_n = 1'b0;
        #1 chk("rst_async_zero", int'(|outs), 0);
        den = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick(3);
        clr_mon();
        den = 1'b1; tick(1);
        chk("rst_first_sof", int'(ctl_sof), 1);
        tick(7); den = 1'b0; tick(20);
        line(8, 20);

        // Overflow: line longer than MAX_W
        mode = 0; clr_mon();
        line(18, 20);
        chk("ovf_keeps", c_keep, 16);
        chk("ovf_err", int'(ctl_err_len), 1);
        chk("ovf_x_sat", int'(ctl_px_x), MAX_W - 1);
        line(18, 20);

        // One-cycle gaps: eol/sol back to back; frame end beats new rise
        clr_mon();
        line(4, 1);
        line(4, 1);
        line(4, 2);
        line(4, 20);
        line(4, 20);
        chk("gap_sof", c_sof, 2);
        chk("gap_sol", c_sol, 4);
        chk("gap_eol", c_eol, 4);
        chk("gap_keeps", c_keep, 16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scl_seq_ctrl.md
# scl_seq_ctrl

Frame/line sequencer for the scaler datapath. It sits between the video input (`scl_i_*`) and the scaler filter/decimation datapath. It tracks frames and lines from the input sync and enable signals, and shadows the scaler configuration so it only changes at frame boundaries. It also produces per-pixel control (keep/decimate, start/end-of-line, coordinates) that the datapath consumes with a fixed one-cycle alignment.

## Interface
Parameters:
- `X_W`, default 12: width of the pixel and line counters.
- `IMG_H`, default 1024: active lines per frame.
- `MAX_W`, default 2048: longest legal line, in pixels.

Ports:
- `clk_scl` in 1: scaler clock. Single clock domain.
- `rst_n_scl` in 1: reset, asynchronous, active-low.
- `scl_i_vsync` in 1: frame sync, active-low. A low level forces a resync.
- `scl_i_hsync` in 1: line sync, active-low. Informational; line boundaries come from `scl_i_data_en`.
- `scl_i_data_en` in 1: input pixel valid. One RGB pixel per high cycle.
- `scl_cfg_mode` in 1: 0 = bypass, 1 = scale.
- `scl_cfg_rsz` in 1: 0 = 1/2 width, 1 = 1/4 width. Used only when mode is 1.
- `scl_cfg_flt` in 2: filter select, passed through shadowed.
- `ctl_mode`, `ctl_rsz` out 1 each: shadowed configuration.
- `ctl_flt` out 2: shadowed configuration.
- `ctl_sof` out 1: pulse on the first pixel of a frame.
- `ctl_sol` out 1: pulse on the first pixel of a line.
- `ctl_eol` out 1: pulse on the last pixel of a line (falling edge of data_en, marks previous pixel).
- `ctl_keep` out 1: the datapath emits an output pixel on this cycle.
- `ctl_px_x` out X_W: input pixel index within the line.
- `ctl_ln_y` out X_W: line index within the frame.
- `ctl_busy` out 1: frame in progress.
- `ctl_err_len` out 1: sticky. Line length mismatch or overflow.

## Operation
- FSM states: IDLE, ACTIVE, HBLANK, DONE.
- IDLE:
  - A rising `scl_i_data_en` moves to ACTIVE.
  - The same cycle latches `scl_cfg_*` into `ctl_*`, asserts `ctl_sof` and `ctl_sol`, clears `ctl_err_len`, and sets x=0, y=0.
- ACTIVE:
  - x increments on each data_en cycle.
  - A falling data_en marks eol. If y=IMG_H-1 → DONE, otherwise → HBLANK with y+1.
- HBLANK: a rising data_en asserts `ctl_sol`, sets x=0 and returns to ACTIVE.
- DONE: lasts one cycle, clears `ctl_busy`, then goes to IDLE.
- `scl_i_vsync` low in any state:
  - Go to IDLE and clear x/y.
  - Retain the shadowed config.
  - Keep `ctl_err_len` as is.
  - This takes priority over all other transitions.
- Config changes mid-frame are ignored until the next IDLE→ACTIVE transition.
- Keep rule, evaluated on the pixel with index x:
  - mode=0: always keep.
  - mode=1, rsz=0: keep when x[0]=1.
  - mode=1, rsz=1: keep when x[1:0]=3.
- Line length:
  - The length of line 0 is recorded as the reference W0.
  - A later line with length ≠ W0 sets `ctl_err_len`.
  - If x reaches MAX_W-1 with data_en still high: set `ctl_err_len`, saturate x, and force `ctl_keep`=0.
- Trailing pixels that do not complete a 2- or 4-pixel group are dropped, never kept.

## Timing
- All outputs are registered.
- Latency: input data_en at cycle n → `ctl_keep`/`ctl_sol`/`ctl_px_x` at cycle n+1. The datapath delays pixels by one register to align.
- `ctl_eol` asserts in the cycle after data_en falls, i.e. aligned with the delayed last pixel's successor slot. Width is one cycle.
- `ctl_sof` and `ctl_sol` are each one cycle wide, aligned with pixel x=0.
- A one-cycle data_en gap still produces eol then sol on consecutive cycles.
- DONE and a new data_en rise in the same cycle: the frame end wins. The next frame starts on the following data_en rise (at least one idle cycle).
- Reset values:
  - FSM=IDLE.
  - `ctl_mode`, `ctl_rsz`, `ctl_flt` = 0.
  - All pulses = 0, `ctl_keep`=0, `ctl_busy`=0, `ctl_err_len`=0.
  - `ctl_px_x`, `ctl_ln_y` = 0.
- Reset mid-frame aborts immediately. No partial pulses follow release.

## Structure
- Shared package `scl_pkg`:
  - FSM state encoding.
  - Mode/resize constants: `SCL_BYPASS`, `SCL_HALF`, `SCL_QUARTER`.
  - Keep-mask function.
- One sub-module, `scl_line_cnt`: x counter with saturation, W0 capture, and length compare. The FSM and the shadow registers stay in the top.

## Test plan
- Mode=0, IMG_H=2, two lines of 8 pixels with 100-cycle gaps → 16 keeps; sol×2, eol×2, sof×1; err=0; busy falls after line 1.
- Mode=1, rsz=0, line of 8 → keeps at x=1,3,5,7 (4 per line); line of 7 → keeps at x=1,3,5 only.
- Mode=1, rsz=1, line of 8 → keeps at x=3,7. Change cfg to mode=0 mid-frame → keep pattern unchanged until the next frame.
- Line 0 = 8 pixels, line 1 = 6 pixels → `ctl_err_len`=1 from the eol of line 1, cleared on the next sof.
- Vsync low at line 1, x=3 → IDLE next cycle, x=y=0, no eol; the next data_en gives sof with y=0.
- Reset asserted mid-line at x=5 → all outputs 0 asynchronously; after release the first data_en gives sof.
